// File: rtl/muldiv_sched.sv
// HI/LO scheduler: issues MULT/DIV to external units, stalls EX while a long
// op is in flight, handles flush/cancel and owns the architectural HI/LO.
module muldiv_sched #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        mul_en,
  output logic        mul_signed,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  input  logic        div_done,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [2:0]  dbg_state
);

  // Handshake: EX presents req_valid/req_op; an instruction is consumed in a
  // cycle where req_valid=1, flush=0 and stall=0. A long op is taken in the
  // accept cycle (stall=1 that cycle) and completes when stall drops in DONE.

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MUL_WAIT = 3'd1,
    ST_DIV_WAIT = 3'd2,
    ST_DONE     = 3'd3,
    ST_CANCEL   = 3'd4
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  // Last counter value of the multiply wait (counter starts at 0).
  localparam logic [2:0] CNT_LAST = 3'(MUL_LAT - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic is_long;
  logic is_mul;

  assign is_long   = ~req_op[2];
  assign is_mul    = is_long & ~req_op[1];
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

  // State register, latency counter and HI/LO; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next state, unit issue, stall and HI/LO write selection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    stall      = 1'b0;
    mul_en     = 1'b0;
    mul_signed = 1'b0;
    mul_x      = 32'd0;
    mul_y      = 32'd0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_x      = 32'd0;
    div_y      = 32'd0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && !flush && is_long) begin
          stall = 1'b1;
          if (is_mul) begin
            mul_en     = 1'b1;
            mul_signed = (req_op == OP_MULT);
            mul_x      = src_a;
            mul_y      = src_b;
            cnt_d      = 3'd0;
            state_d    = ST_MUL_WAIT;
          end else begin
            div_start  = 1'b1;
            div_signed = (req_op == OP_DIV);
            div_x      = src_a;
            div_y      = src_b;
            state_d    = ST_DIV_WAIT;
          end
        end
      end
      ST_MUL_WAIT: begin
        stall = 1'b1;
        if (flush) begin
          // Product is simply never sampled; nothing to drain.
          cnt_d   = 3'd0;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          hi_d    = mul_result[63:32];
          lo_d    = mul_result[31:0];
          cnt_d   = 3'd0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_DIV_WAIT: begin
        stall = 1'b1;
        if (flush) begin
          // Divider cannot be aborted; drain it in CANCEL.
          state_d = ST_CANCEL;
        end else if (div_done) begin
          lo_d    = div_q;
          hi_d    = div_r;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_CANCEL: begin
        stall = req_valid;
        if (div_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Moves to HI/LO only retire when the instruction is actually consumed.
    if (req_valid && !stall && !flush) begin
      if (req_op == OP_MTHI) begin
        hi_d = src_a;
      end else if (req_op == OP_MTLO) begin
        lo_d = src_a;
      end
    end
  end

  // MFHI/MFLO read path.
  always_comb begin
    rd_data = 32'd0;
    if (req_op == OP_MFHI) begin
      rd_data = hi_q;
    end else if (req_op == OP_MFLO) begin
      rd_data = lo_q;
    end
  end

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: table of HI/LO instructions plus
// hand-written flush, cancel and reset sequences.
module tb_muldiv_sched;

  localparam int MUL_LAT = 2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] src_a, src_b;
  logic        flush;
  logic        stall;
  logic        mul_en, mul_signed;
  logic [31:0] mul_x, mul_y;
  logic [63:0] mul_result;
  logic        div_start, div_signed;
  logic [31:0] div_x, div_y;
  logic        div_done;
  logic [31:0] div_q, div_r;
  logic [31:0] rd_data, hi, lo;
  logic [2:0]  dbg_state;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  muldiv_sched #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .src_a(src_a), .src_b(src_b), .flush(flush), .stall(stall),
    .mul_en(mul_en), .mul_signed(mul_signed), .mul_x(mul_x), .mul_y(mul_y),
    .mul_result(mul_result), .div_start(div_start), .div_signed(div_signed),
    .div_x(div_x), .div_y(div_y), .div_done(div_done), .div_q(div_q),
    .div_r(div_r), .rd_data(rd_data), .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- external unit models ----------------
  int          mul_k = -1;
  logic [63:0] mul_prod;
  int          div_k = -1;
  int          div_lat = 1;
  logic [31:0] div_qv, div_rv;

  // Called at each negedge: present results only in their valid cycle.
  task automatic models_advance();
    if (mul_k >= 0) mul_k++;
    if (mul_k > MUL_LAT) mul_k = -1;
    mul_result = (mul_k == MUL_LAT) ? mul_prod : 64'hBAD0_BAD0_BAD0_BAD0;
    if (div_k >= 0) div_k++;
    if (div_k > div_lat) div_k = -1;
    div_done = (div_k == div_lat);
    div_q    = (div_k == div_lat) ? div_qv : 32'hBADD_BADD;
    div_r    = (div_k == div_lat) ? div_rv : 32'hBADD_BADD;
  endtask

  // Called after outputs settle: latch operands on an issue pulse.
  task automatic models_capture();
    longint sx, sy;
    int     ix, iy;
    if (mul_en) begin
      mul_k = 0;
      if (mul_signed) begin
        sx = longint'($signed(mul_x));
        sy = longint'($signed(mul_y));
        mul_prod = 64'(sx * sy);
      end else begin
        mul_prod = {32'd0, mul_x} * {32'd0, mul_y};
      end
    end
    if (div_start) begin
      div_k = 0;
      if (div_y == 32'd0) begin
        div_qv = 32'hFFFF_FFFF;
        div_rv = div_x;
      end else if (div_signed) begin
        ix = int'($signed(div_x));
        iy = int'($signed(div_y));
        div_qv = 32'(ix / iy);
        div_rv = 32'(ix % iy);
      end else begin
        div_qv = div_x / div_y;
        div_rv = div_x % div_y;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc_begin();
    @(negedge clk);
    models_advance();
  endtask

  task automatic cyc_sample();
    #1;
    models_capture();
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          dlat;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic [31:0] exp_rd;
    int          exp_stalls;
    logic        exp_sgn;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input int dlat, input logic [31:0] eh, input logic [31:0] el,
                              input logic [31:0] er, input int es, input logic sg);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.dlat = dlat;
    v.exp_hi = eh; v.exp_lo = el; v.exp_rd = er; v.exp_stalls = es; v.exp_sgn = sg;
    return v;
  endfunction

  // Holds the request until the first non-stalled cycle, then retires it.
  task automatic run_vec(input int idx, input vec_t v);
    int   stalls = 0;
    int   cyc = 0;
    int   mul_pulses = 0;
    int   div_pulses = 0;
    logic sgn_seen = 1'b0;
    bit   fin = 1'b0;
    bit   is_long;
    bit   is_mul;
    is_long = (v.op <= OP_DIVU);
    is_mul  = (v.op == OP_MULT) || (v.op == OP_MULTU);
    div_lat = v.dlat;
    exp_q.push_back(v.exp_hi);
    exp_q.push_back(v.exp_lo);
    cyc_begin();
    req_valid = 1'b1; req_op = v.op; src_a = v.a; src_b = v.b;
    while (!fin) begin
      cyc_sample();
      if (mul_en) begin mul_pulses++; sgn_seen = mul_signed; end
      if (div_start) begin div_pulses++; sgn_seen = div_signed; end
      if (cyc == 0) check($sformatf("v%0d_rd_data", idx), rd_data, v.exp_rd);
      if (stall) stalls++;
      else fin = 1'b1;
      cyc++;
      if (!fin && cyc > 40) begin
        n_tests++; n_fail++;
        $display("FAIL v%0d_timeout: stall still %0b after %0d cycles", idx, stall, cyc);
        fin = 1'b1;
      end
      cyc_begin();
    end
    req_valid = 1'b0; src_a = 32'd0; src_b = 32'd0;
    cyc_sample();
    check($sformatf("v%0d_stalls", idx), stalls, v.exp_stalls);
    check($sformatf("v%0d_mul_pulses", idx), mul_pulses, is_mul ? 1 : 0);
    check($sformatf("v%0d_div_pulses", idx), div_pulses, (is_long && !is_mul) ? 1 : 0);
    if (is_long) check($sformatf("v%0d_signed", idx), sgn_seen, v.exp_sgn);
    check($sformatf("v%0d_state_idle", idx), dbg_state, 3'd0);
    check($sformatf("v%0d_hi", idx), hi, exp_q.pop_front());
    check($sformatf("v%0d_lo", idx), lo, exp_q.pop_front());
  endtask

  vec_t vecs[13];

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- main test ----------------
  initial begin
    int n;
    //            op        a             b             dlat hi            lo            rd            st sgn
    vecs[0]  = mk(OP_MULT,  32'hFFFFFFFD, 32'h00000005, 1, 32'hFFFFFFFF, 32'hFFFFFFF1, 32'h0,        3, 1'b1);
    vecs[1]  = mk(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 32'h0,        3, 1'b0);
    vecs[2]  = mk(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 5, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0,        6, 1'b1);
    vecs[3]  = mk(OP_DIVU,  32'hFFFFFFF9, 32'h00000002, 1, 32'h00000001, 32'h7FFFFFFC, 32'h0,        2, 1'b0);
    vecs[4]  = mk(OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 1, 32'h3FFFFFFF, 32'h00000001, 32'h0,        3, 1'b1);
    vecs[5]  = mk(OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000000, 32'h00000001, 32'h0,        3, 1'b1);
    vecs[6]  = mk(OP_DIV,   32'h00000064, 32'hFFFFFFF9, 3, 32'h00000002, 32'hFFFFFFF2, 32'h0,        4, 1'b1);
    vecs[7]  = mk(OP_DIVU,  32'h00000005, 32'h00000000, 2, 32'h00000005, 32'hFFFFFFFF, 32'h0,        3, 1'b0);
    vecs[8]  = mk(OP_MTHI,  32'h12345678, 32'h0,        1, 32'h12345678, 32'hFFFFFFFF, 32'h0,        0, 1'b0);
    vecs[9]  = mk(OP_MTLO,  32'hCAFEF00D, 32'h0,        1, 32'h12345678, 32'hCAFEF00D, 32'h0,        0, 1'b0);
    vecs[10] = mk(OP_MFHI,  32'h0,        32'h0,        1, 32'h12345678, 32'hCAFEF00D, 32'h12345678, 0, 1'b0);
    vecs[11] = mk(OP_MFLO,  32'h0,        32'h0,        1, 32'h12345678, 32'hCAFEF00D, 32'hCAFEF00D, 0, 1'b0);
    vecs[12] = mk(OP_MULTU, 32'h00010000, 32'h00010000, 1, 32'h00000001, 32'h00000000, 32'h0,        3, 1'b0);

    // ---- reset ----
    reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; src_a = 32'd0; src_b = 32'd0;
    flush = 1'b0; mul_result = 64'd0; div_done = 1'b0; div_q = 32'd0; div_r = 32'd0;
    repeat (3) @(posedge clk);
    cyc_begin(); reset = 1'b0; cyc_sample();
    check("rst_stall", stall, 1'b0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_state", dbg_state, 3'd0);
    check("rst_mul_en", mul_en, 1'b0);
    check("rst_div_start", div_start, 1'b0);

    // ---- table ----
    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);
    // hi=00000001 lo=00000000 now

    // ---- MTHI then MFHI back to back ----
    cyc_begin(); req_valid = 1'b1; req_op = OP_MTHI; src_a = 32'h12345678; cyc_sample();
    check("mthi_stall", stall, 1'b0);
    cyc_begin(); req_op = OP_MFHI; src_a = 32'd0; cyc_sample();
    check("mfhi_rd", rd_data, 32'h12345678);
    check("mfhi_stall", stall, 1'b0);
    cyc_begin(); req_valid = 1'b0; cyc_sample();

    // ---- flush in IDLE blocks accept and MT write ----
    cyc_begin(); req_valid = 1'b1; req_op = OP_MULT; src_a = 32'd3; src_b = 32'd4; flush = 1'b1; cyc_sample();
    check("flush_idle_stall", stall, 1'b0);
    check("flush_idle_mul_en", mul_en, 1'b0);
    cyc_begin(); req_op = OP_MTLO; src_a = 32'h55; cyc_sample();
    cyc_begin(); req_valid = 1'b0; flush = 1'b0; cyc_sample();
    check("flush_idle_lo", lo, 32'd0);
    check("flush_idle_state", dbg_state, 3'd0);

    // ---- flush in MUL_WAIT drops the product ----
    cyc_begin(); req_valid = 1'b1; req_op = OP_MTLO; src_a = 32'h11112222; cyc_sample();
    cyc_begin(); req_op = OP_MULT; src_a = 32'd3; src_b = 32'd4; cyc_sample();
    check("mflush_mul_en", mul_en, 1'b1);
    cyc_begin(); flush = 1'b1; cyc_sample();
    check("mflush_stall", stall, 1'b1);
    cyc_begin(); flush = 1'b0; req_valid = 1'b0; cyc_sample();
    check("mflush_state", dbg_state, 3'd0);
    check("mflush_stall_after", stall, 1'b0);
    cyc_begin(); cyc_sample();
    check("mflush_lo", lo, 32'h11112222);
    check("mflush_hi", hi, 32'h12345678);

    // ---- flush in DIV_WAIT -> CANCEL, MFLO waits for div_done ----
    div_lat = 6;
    cyc_begin(); req_valid = 1'b1; req_op = OP_DIV; src_a = 32'd100; src_b = 32'd7; cyc_sample();
    check("cancel_div_start", div_start, 1'b1);
    cyc_begin(); cyc_sample();
    cyc_begin(); flush = 1'b1; cyc_sample();
    cyc_begin(); flush = 1'b0; req_op = OP_MFLO; src_a = 32'd0; src_b = 32'd0; cyc_sample();
    check("cancel_state", dbg_state, 3'd4);
    check("cancel_div_start_low", div_start, 1'b0);
    n = 0;
    while (stall && n < 20) begin
      n++;
      cyc_begin(); cyc_sample();
    end
    check("cancel_mflo_stalls", n, 4);
    check("cancel_mflo_rd", rd_data, 32'h11112222);
    check("cancel_hi", hi, 32'h12345678);
    check("cancel_lo", lo, 32'h11112222);
    check("cancel_state_idle", dbg_state, 3'd0);
    cyc_begin(); req_valid = 1'b0; cyc_sample();

    // ---- reset in MUL_WAIT ----
    cyc_begin(); req_valid = 1'b1; req_op = OP_MTHI; src_a = 32'hAAAA0000; cyc_sample();
    cyc_begin(); req_op = OP_MULT; src_a = 32'd5; src_b = 32'd6; cyc_sample();
    check("rmul_mul_en", mul_en, 1'b1);
    cyc_begin(); reset = 1'b1; req_valid = 1'b0; cyc_sample();
    check("rmul_pre_hi", hi, 32'hAAAA0000);
    check("rmul_pre_state", dbg_state, 3'd1);
    cyc_begin(); reset = 1'b0; cyc_sample();
    check("rmul_hi", hi, 32'd0);
    check("rmul_lo", lo, 32'd0);
    check("rmul_stall", stall, 1'b0);
    check("rmul_state", dbg_state, 3'd0);
    check("rmul_mul_signed", mul_signed, 1'b0);
    cyc_begin(); cyc_sample();
    check("rmul_late_hi", hi, 32'd0);
    check("rmul_late_lo", lo, 32'd0);

    // ---- report ----
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
